cr_osf_ob_mon: RTL and testbench

- Multi-channel successor to the OSF outbound support/stat logic.
- Sits on the OSF outbound FIFO read side and watches the stream as the AXI master drains it.
- Tracks TLV framing per channel and emits per-channel command-active, CQE-exit and frame/byte-count events.
- Keeps saturating per-channel byte and frame accumulators, readable through an indexed read/clear port.
- Data width and channel count are parametrised.

---
 rtl/cr_osf_ob_mon_pkg.sv | 49 ++++
 rtl/cr_osf_ob_mon_ch.sv | 121 ++++++++++++
 rtl/cr_osf_ob_mon.sv | 143 ++++++++++++++
 tb/tb_cr_osf_ob_mon.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_osf_ob_mon_pkg.sv
// Shared types for the OSF outbound monitor: TLV type codes, word-0 layout,
// per-channel FSM states, the event record and a strobe popcount helper.
package cr_osf_ob_mon_pkg;

  localparam logic [7:0] TLV_RQE      = 8'h01;
  localparam logic [7:0] TLV_CQE      = 8'h02;
  localparam logic [7:0] TLV_DATA     = 8'h03;
  localparam logic [7:0] TLV_DATA_UNK = 8'h04;

  typedef struct packed {
    logic [7:0]  tlv_len;
    logic [15:0] tlv_rsvd;
    logic [7:0]  tlv_type;
  } tlv_word_0_t;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_RQE  = 2'd1,
    CMD_CQE  = 2'd2
  } cmd_st_e;

  typedef enum logic {
    CQE_IDLE  = 1'b0,
    CQE_FOUND = 1'b1
  } cqe_st_e;

  typedef enum logic {
    D_IDLE  = 1'b0,
    D_FOUND = 1'b1
  } data_st_e;

  // Sized for the widest build: 32 strobes and 16 channels.
  localparam int EV_AMT_W = 6;
  localparam int EV_CH_W  = 4;

  typedef struct packed {
    logic                stb;
    logic [EV_AMT_W-1:0] amt;
    logic [EV_CH_W-1:0]  ch;
  } ob_mon_ev_t;

  function automatic logic [EV_AMT_W-1:0] popcount(input logic [31:0] v);
    logic [EV_AMT_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + EV_AMT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/cr_osf_ob_mon_ch.sv
// One channel of the outbound monitor: command, CQE and DATA framing FSMs
// plus saturating byte/frame accumulators with clear-then-add semantics.
module cr_osf_ob_mon_ch
  import cr_osf_ob_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                acc_i,
  input  logic                first_i,
  input  logic                last_i,
  input  logic [7:0]          type_i,
  input  logic [EV_AMT_W-1:0] amt_i,
  input  logic                clr_i,
  output logic                cmd_active_o,
  output logic                cqe_exit_o,
  output logic                frame_hit_o,
  output logic                bytes_hit_o,
  output logic [CNT_W-1:0]    bytes_o,
  output logic [CNT_W-1:0]    frames_o
);

  cmd_st_e          cmd_q, cmd_d;
  cqe_st_e          cqe_q, cqe_d;
  data_st_e         dat_q, dat_d;
  logic             cqe_exit_q, cqe_exit_d;
  logic [CNT_W-1:0] bytes_q, bytes_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             is_rqe, is_cqe, is_dat;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [EV_AMT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    cmd_d       = cmd_q;
    cqe_d       = cqe_q;
    dat_d       = dat_q;
    cqe_exit_d  = 1'b0;
    frame_hit_o = 1'b0;
    bytes_hit_o = 1'b0;
    is_rqe      = first_i && (type_i == TLV_RQE);
    is_cqe      = first_i && (type_i == TLV_CQE);
    is_dat      = first_i && ((type_i == TLV_DATA) || (type_i == TLV_DATA_UNK));

    // A single-beat CQE closes the command in the same cycle it opens the CQE.
    case (cmd_q)
      CMD_IDLE: if (acc_i && is_rqe) cmd_d = CMD_RQE;
      CMD_RQE:  if (acc_i && is_cqe) cmd_d = last_i ? CMD_IDLE : CMD_CQE;
      CMD_CQE:  if (acc_i && last_i) cmd_d = CMD_IDLE;
      default:  cmd_d = CMD_IDLE;
    endcase

    case (cqe_q)
      CQE_IDLE: begin
        if (acc_i && is_cqe) begin
          if (last_i) cqe_exit_d = 1'b1;
          else        cqe_d      = CQE_FOUND;
        end
      end
      CQE_FOUND: begin
        if (acc_i && last_i) begin
          cqe_d      = CQE_IDLE;
          cqe_exit_d = 1'b1;
        end
      end
      default: cqe_d = CQE_IDLE;
    endcase

    case (dat_q)
      D_IDLE: begin
        if (acc_i && is_dat) begin
          frame_hit_o = 1'b1;
          bytes_hit_o = 1'b1;
          if (!last_i) dat_d = D_FOUND;
        end
      end
      D_FOUND: begin
        if (acc_i) begin
          bytes_hit_o = 1'b1;
          if (last_i) dat_d = D_IDLE;
        end
      end
      default: dat_d = D_IDLE;
    endcase

    // Clear first so a coincident increment survives the clear.
    bytes_d  = clr_i ? '0 : bytes_q;
    frames_d = clr_i ? '0 : frames_q;
    if (bytes_hit_o) bytes_d  = sat_add(bytes_d, amt_i);
    if (frame_hit_o) frames_d = sat_add(frames_d, EV_AMT_W'(1));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cmd_q      <= CMD_IDLE;
      cqe_q      <= CQE_IDLE;
      dat_q      <= D_IDLE;
      cqe_exit_q <= 1'b0;
      bytes_q    <= '0;
      frames_q   <= '0;
    end else begin
      cmd_q      <= cmd_d;
      cqe_q      <= cqe_d;
      dat_q      <= dat_d;
      cqe_exit_q <= cqe_exit_d;
      bytes_q    <= bytes_d;
      frames_q   <= frames_d;
    end
  end

  assign cmd_active_o = (cmd_q != CMD_IDLE);
  assign cqe_exit_o   = cqe_exit_q;
  assign bytes_o      = bytes_q;
  assign frames_o     = frames_q;

endmodule

// File: rtl/cr_osf_ob_mon.sv
// OSF outbound stream monitor: decodes accepted beats, steers them to the
// per-channel trackers, registers events/stall stats and serves the read port.
module cr_osf_ob_mon
  import cr_osf_ob_mon_pkg::*;
#(
  parameter int BYTES  = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ob_tvalid,
  input  logic [8*BYTES-1:0]           ob_tdata,
  input  logic [BYTES-1:0]             ob_tstrb,
  input  logic [1:0]                   ob_tuser,
  input  logic [CH_W-1:0]              ob_tid,
  input  logic [NUM_CH-1:0]            ob_fifo_empty,
  input  logic                         axi_mstr_rd,
  input  logic                         ib_stall_dat,
  input  logic                         ib_stall_pdt,
  output logic [NUM_CH-1:0]            cmd_active,
  output logic [NUM_CH-1:0]            cqe_exit,
  output logic                         frame_stb,
  output logic                         bytes_stb,
  output logic [$clog2(BYTES+1)-1:0]   bytes_amt,
  output logic [CH_W-1:0]              ev_ch,
  output logic [NUM_CH-1:0]            stat_ob_stall,
  output logic [NUM_CH-1:0]            stat_sys_bp,
  output logic                         stat_dat_stall,
  output logic                         stat_pdt_stall,
  input  logic [CH_W-1:0]              rd_ch,
  input  logic                         rd_clr,
  output logic [CNT_W-1:0]             rd_bytes,
  output logic [CNT_W-1:0]             rd_frames
);

  localparam int AMT_W = $clog2(BYTES+1);

  logic                acc;
  logic [31:0]         strb32;
  logic [EV_AMT_W-1:0] amt;
  tlv_word_0_t         w0;
  logic [NUM_CH-1:0]   acc_ch, clr_ch, frame_hit, bytes_hit, cmd_act, cqe_exit_ch;
  logic [CNT_W-1:0]    bytes_vec  [NUM_CH];
  logic [CNT_W-1:0]    frames_vec [NUM_CH];

  ob_mon_ev_t          ev_d, ev_q;
  logic                frame_stb_d, frame_stb_q;
  logic [NUM_CH-1:0]   stat_ob_stall_q, stat_sys_bp_q;
  logic                stat_dat_stall_q, stat_pdt_stall_q;
  logic [CNT_W-1:0]    rd_bytes_d, rd_bytes_q, rd_frames_d, rd_frames_q;
  logic                unused_bits;

  always_comb begin
    acc    = ob_tvalid && axi_mstr_rd;
    strb32 = '0;
    strb32[BYTES-1:0] = ob_tstrb;
    amt    = popcount(strb32);
    w0     = tlv_word_0_t'(ob_tdata[31:0]);
    for (int i = 0; i < NUM_CH; i++) begin
      acc_ch[i] = acc && (ob_tid == CH_W'(i));
      clr_ch[i] = rd_clr && (rd_ch == CH_W'(i));
    end
  end

  // Only the payload type byte and strobes matter; the rest of the beat is ignored.
  assign unused_bits = ^{ob_tdata, w0, ev_q};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cr_osf_ob_mon_ch #(.CNT_W(CNT_W)) u_ch (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .acc_i        (acc_ch[g]),
      .first_i      (ob_tuser[0]),
      .last_i       (ob_tuser[1]),
      .type_i       (w0.tlv_type),
      .amt_i        (amt),
      .clr_i        (clr_ch[g]),
      .cmd_active_o (cmd_act[g]),
      .cqe_exit_o   (cqe_exit_ch[g]),
      .frame_hit_o  (frame_hit[g]),
      .bytes_hit_o  (bytes_hit[g]),
      .bytes_o      (bytes_vec[g]),
      .frames_o     (frames_vec[g])
    );
  end

  always_comb begin
    ev_d        = '0;
    frame_stb_d = |frame_hit;
    if (|bytes_hit) begin
      ev_d.stb = 1'b1;
      ev_d.amt = amt;
    end
    if (frame_stb_d || ev_d.stb) ev_d.ch = EV_CH_W'(ob_tid);

    rd_bytes_d  = '0;
    rd_frames_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_bytes_d  = bytes_vec[i];
        rd_frames_d = frames_vec[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ev_q             <= '0;
      frame_stb_q      <= 1'b0;
      stat_ob_stall_q  <= '0;
      stat_sys_bp_q    <= '0;
      stat_dat_stall_q <= 1'b0;
      stat_pdt_stall_q <= 1'b0;
      rd_bytes_q       <= '0;
      rd_frames_q      <= '0;
    end else begin
      ev_q             <= ev_d;
      frame_stb_q      <= frame_stb_d;
      stat_ob_stall_q  <= ob_fifo_empty & cmd_act;
      stat_sys_bp_q    <= ~ob_fifo_empty & {NUM_CH{~axi_mstr_rd}};
      stat_dat_stall_q <= ib_stall_dat;
      stat_pdt_stall_q <= ib_stall_pdt;
      rd_bytes_q       <= rd_bytes_d;
      rd_frames_q      <= rd_frames_d;
    end
  end

  assign cmd_active     = cmd_act;
  assign cqe_exit       = cqe_exit_ch;
  assign frame_stb      = frame_stb_q;
  assign bytes_stb      = ev_q.stb;
  assign bytes_amt      = ev_q.amt[AMT_W-1:0];
  assign ev_ch          = ev_q.ch[CH_W-1:0];
  assign stat_ob_stall  = stat_ob_stall_q;
  assign stat_sys_bp    = stat_sys_bp_q;
  assign stat_dat_stall = stat_dat_stall_q;
  assign stat_pdt_stall = stat_pdt_stall_q;
  assign rd_bytes       = rd_bytes_q;
  assign rd_frames      = rd_frames_q;

endmodule

// File: tb/tb_cr_osf_ob_mon.sv
// Scoreboard bench for cr_osf_ob_mon: directed TLV sequences push expected
// events/reads into queues; a negedge monitor pops and compares them.
module tb_cr_osf_ob_mon;
  import cr_osf_ob_mon_pkg::*;

  localparam int BYTES  = 8;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 16;
  localparam int AMT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                ob_tvalid;
  logic [8*BYTES-1:0]  ob_tdata;
  logic [BYTES-1:0]    ob_tstrb;
  logic [1:0]          ob_tuser;
  logic [CH_W-1:0]     ob_tid;
  logic [NUM_CH-1:0]   ob_fifo_empty;
  logic                axi_mstr_rd;
  logic                ib_stall_dat;
  logic                ib_stall_pdt;
  logic [NUM_CH-1:0]   cmd_active;
  logic [NUM_CH-1:0]   cqe_exit;
  logic                frame_stb;
  logic                bytes_stb;
  logic [AMT_W-1:0]    bytes_amt;
  logic [CH_W-1:0]     ev_ch;
  logic [NUM_CH-1:0]   stat_ob_stall;
  logic [NUM_CH-1:0]   stat_sys_bp;
  logic                stat_dat_stall;
  logic                stat_pdt_stall;
  logic [CH_W-1:0]     rd_ch;
  logic                rd_clr;
  logic [CNT_W-1:0]    rd_bytes;
  logic [CNT_W-1:0]    rd_frames;

  cr_osf_ob_mon #(.BYTES(BYTES), .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ob_tvalid(ob_tvalid), .ob_tdata(ob_tdata),
    .ob_tstrb(ob_tstrb), .ob_tuser(ob_tuser), .ob_tid(ob_tid),
    .ob_fifo_empty(ob_fifo_empty), .axi_mstr_rd(axi_mstr_rd),
    .ib_stall_dat(ib_stall_dat), .ib_stall_pdt(ib_stall_pdt),
    .cmd_active(cmd_active), .cqe_exit(cqe_exit), .frame_stb(frame_stb),
    .bytes_stb(bytes_stb), .bytes_amt(bytes_amt), .ev_ch(ev_ch),
    .stat_ob_stall(stat_ob_stall), .stat_sys_bp(stat_sys_bp),
    .stat_dat_stall(stat_dat_stall), .stat_pdt_stall(stat_pdt_stall),
    .rd_ch(rd_ch), .rd_clr(rd_clr), .rd_bytes(rd_bytes), .rd_frames(rd_frames)
  );

  typedef struct packed {
    logic             fr;
    logic [AMT_W-1:0] amt;
    logic [CH_W-1:0]  ch;
  } ev_t;

  typedef struct packed {
    logic [CNT_W-1:0] b;
    logic [CNT_W-1:0] f;
  } rd_t;

  ev_t             evq[$];
  logic [CH_W-1:0] cqq[$];
  rd_t             rdq[$];

  int   checks = 0;
  int   errors = 0;
  logic rd_issue = 1'b0;
  logic rd_vld   = 1'b0;

  always @(posedge clk) rd_vld <= rd_issue;

  // Monitor: every presented output is matched against the oldest expectation.
  ev_t               m_ev;
  rd_t               m_rd;
  logic [CH_W-1:0]   m_ch;
  logic [NUM_CH-1:0] m_oh;
  always @(negedge clk) begin
    if (frame_stb || bytes_stb) begin
      checks++;
      if (evq.size() == 0) begin
        errors++;
        $display("FAIL ev_unexpected got fr=%0b by=%0b amt=%0d ch=%0d required none",
                 frame_stb, bytes_stb, bytes_amt, ev_ch);
      end else begin
        m_ev = evq.pop_front();
        if ({frame_stb, bytes_stb, bytes_amt, ev_ch} !== {m_ev.fr, 1'b1, m_ev.amt, m_ev.ch}) begin
          errors++;
          $display("FAIL ev got fr=%0b by=%0b amt=%0d ch=%0d required fr=%0b by=1 amt=%0d ch=%0d",
                   frame_stb, bytes_stb, bytes_amt, ev_ch, m_ev.fr, m_ev.amt, m_ev.ch);
        end
      end
    end
    if (cqe_exit != '0) begin
      checks++;
      if (cqq.size() == 0) begin
        errors++;
        $display("FAIL cqe_unexpected got %b required none", cqe_exit);
      end else begin
        m_ch = cqq.pop_front();
        m_oh = '0;
        m_oh[m_ch] = 1'b1;
        if (cqe_exit !== m_oh) begin
          errors++;
          $display("FAIL cqe_exit got %b required %b", cqe_exit, m_oh);
        end
      end
    end
    if (rd_vld) begin
      checks++;
      if (rdq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got b=%h f=%h", rd_bytes, rd_frames);
      end else begin
        m_rd = rdq.pop_front();
        if ({rd_bytes, rd_frames} !== {m_rd.b, m_rd.f}) begin
          errors++;
          $display("FAIL rd got b=%h f=%h required b=%h f=%h", rd_bytes, rd_frames, m_rd.b, m_rd.f);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, act, req);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    ob_tvalid   = 1'b0;
    ob_tuser    = 2'b00;
    axi_mstr_rd = 1'b1;
    rd_clr      = 1'b0;
    rd_issue    = 1'b0;
  endtask

  task automatic b(input int ch, input logic f, input logic l, input logic [7:0] typ,
                   input logic [7:0] strb, input logic rd);
    nxt();
    ob_tvalid   = 1'b1;
    ob_tid      = CH_W'(ch);
    ob_tuser    = {l, f};
    ob_tdata    = {56'hA5A5_0000_00C3_3C, typ};
    ob_tstrb    = strb;
    axi_mstr_rd = rd;
  endtask

  task automatic ev(input logic fr, input int amt, input int ch);
    ev_t e;
    e.fr  = fr;
    e.amt = AMT_W'(amt);
    e.ch  = CH_W'(ch);
    evq.push_back(e);
  endtask

  task automatic cq(input int ch);
    cqq.push_back(CH_W'(ch));
  endtask

  task automatic r(input int ch, input logic clr, input logic [CNT_W-1:0] eb, input logic [CNT_W-1:0] ef);
    rd_t x;
    rd_ch    = CH_W'(ch);
    rd_clr   = clr;
    rd_issue = 1'b1;
    x.b = eb;
    x.f = ef;
    rdq.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0; ob_tvalid = 1'b0; ob_tdata = '0; ob_tstrb = '0; ob_tuser = '0;
    ob_tid = '0; ob_fifo_empty = '1; axi_mstr_rd = 1'b1; ib_stall_dat = 1'b0;
    ib_stall_pdt = 1'b0; rd_ch = '0; rd_clr = 1'b0;

    nxt(); nxt(); nxt();
    @(negedge clk);
    chk("reset_events", {cmd_active, cqe_exit, frame_stb, bytes_stb, bytes_amt, ev_ch}, '0);
    chk("reset_stats", {stat_ob_stall, stat_sys_bp, stat_dat_stall, stat_pdt_stall}, '0);
    chk("reset_rd", {rd_bytes, rd_frames}, '0);
    rst_n = 1'b1;

    // Full command on ch2: RQE, 3-beat DATA (8,8,4), 2-beat CQE.
    b(2, 1, 1, TLV_RQE, 8'hFF, 1);
    b(2, 1, 0, TLV_DATA, 8'hFF, 1); ev(1, 8, 2);
    @(negedge clk); chk("cmd_act_rqe", cmd_active, 4'b0100);
    b(2, 0, 0, TLV_DATA, 8'hFF, 1); ev(0, 8, 2);
    b(2, 0, 1, TLV_DATA, 8'h0F, 1); ev(0, 4, 2);
    b(2, 1, 0, TLV_CQE, 8'hFF, 1);
    b(2, 0, 1, TLV_CQE, 8'hFF, 1); cq(2);
    @(negedge clk); chk("cmd_act_cqe_last", cmd_active, 4'b0100);
    nxt();
    @(negedge clk); chk("cmd_act_drop", cmd_active, 4'b0000);
    r(2, 1, 16'd20, 16'd1);

    // Stall statistics with ch0 inside a command, then a single-beat CQE.
    b(0, 1, 1, TLV_RQE, 8'hFF, 1);
    nxt(); ob_fifo_empty = 4'b1011; axi_mstr_rd = 1'b0; ib_stall_dat = 1'b1;
    nxt(); ob_fifo_empty = 4'hF; ib_stall_dat = 1'b0; ib_stall_pdt = 1'b1;
    @(negedge clk);
    chk("stat_ob_stall", stat_ob_stall, 4'b0001);
    chk("stat_sys_bp", stat_sys_bp, 4'b0100);
    chk("stat_dat_pdt", {stat_dat_stall, stat_pdt_stall}, 2'b10);
    nxt(); ib_stall_pdt = 1'b0;
    @(negedge clk);
    chk("stat_pdt_sys_bp", {stat_pdt_stall, stat_dat_stall, stat_sys_bp}, {1'b1, 1'b0, 4'b0000});
    b(0, 1, 1, TLV_CQE, 8'hFF, 1); cq(0);
    nxt();
    @(negedge clk); chk("cmd_act_single_cqe", cmd_active, 4'b0000);

    // Same DATA TLV with axi_mstr_rd toggling 1,0,1,0,1.
    b(2, 1, 0, TLV_DATA, 8'hFF, 1); ev(1, 8, 2);
    b(2, 0, 0, TLV_DATA, 8'hFF, 0);
    b(2, 0, 0, TLV_DATA, 8'hFF, 1); ev(0, 8, 2);
    b(2, 0, 1, TLV_DATA, 8'h0F, 0);
    b(2, 0, 1, TLV_DATA, 8'h0F, 1); ev(0, 4, 2);
    nxt(); r(2, 1, 16'd20, 16'd1);

    // Interleaved DATA_UNK on ch0 (16 bytes) and DATA on ch1 (24 bytes).
    b(0, 1, 0, TLV_DATA_UNK, 8'hFF, 1); ev(1, 8, 0);
    b(1, 1, 0, TLV_DATA, 8'hFF, 1);     ev(1, 8, 1);
    b(0, 0, 1, TLV_DATA_UNK, 8'hFF, 1); ev(0, 8, 0);
    b(1, 0, 0, TLV_DATA, 8'hFF, 1);     ev(0, 8, 1);
    b(1, 0, 1, TLV_DATA, 8'hFF, 1);     ev(0, 8, 1);
    nxt(); r(0, 1, 16'd16, 16'd1);
    nxt(); r(1, 1, 16'd24, 16'd1);

    // Clear coinciding with an accepted 5-byte beat on ch0; zero-strobe beat on ch3.
    b(0, 1, 1, TLV_DATA, 8'hFF, 1); ev(1, 8, 0);
    b(0, 1, 1, TLV_DATA, 8'h1F, 1); ev(1, 5, 0); r(0, 1, 16'd8, 16'd1);
    b(3, 1, 1, TLV_DATA, 8'h00, 1); ev(1, 0, 3);
    nxt(); r(0, 0, 16'd5, 16'd1);
    nxt(); r(3, 1, 16'd0, 16'd1);

    // Saturation on ch1: climb to 0xFFFD, then two 8-byte beats pin at 0xFFFF.
    b(1, 1, 0, TLV_DATA, 8'hFF, 1); ev(1, 8, 1);
    for (int i = 0; i < 8190; i++) begin
      b(1, 0, 0, TLV_DATA, 8'hFF, 1); ev(0, 8, 1);
    end
    b(1, 0, 1, TLV_DATA, 8'h1F, 1); ev(0, 5, 1);
    nxt(); r(1, 0, 16'hFFFD, 16'd1);
    b(1, 1, 1, TLV_DATA, 8'hFF, 1); ev(1, 8, 1);
    nxt(); r(1, 0, 16'hFFFF, 16'd2);
    b(1, 1, 1, TLV_DATA, 8'hFF, 1); ev(1, 8, 1);
    nxt(); r(1, 1, 16'hFFFF, 16'd3);
    nxt(); r(1, 0, 16'd0, 16'd0);

    // Reset in the middle of a DATA TLV on ch3.
    b(3, 1, 0, TLV_DATA, 8'hFF, 1); ev(1, 8, 3);
    b(3, 0, 0, TLV_DATA, 8'hFF, 1); ev(0, 8, 3);
    nxt(); rst_n = 1'b0;
    nxt(); nxt();
    @(negedge clk);
    chk("midreset_events", {cmd_active, cqe_exit, frame_stb, bytes_stb, bytes_amt, ev_ch}, '0);
    chk("midreset_rd", {rd_bytes, rd_frames}, '0);
    rst_n = 1'b1;
    b(3, 0, 1, TLV_DATA, 8'hFF, 1);
    nxt(); r(3, 0, 16'd0, 16'd0);
    nxt();

    for (int i = 0; i < 20 && (evq.size() + cqq.size() + rdq.size()) != 0; i++) @(negedge clk);
    chk("queues_drained", 64'(evq.size() + cqq.size() + rdq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
